// File: rtl/lcd_ctrl_win_pkg.sv
// Shared command codes, FSM states and address-width helper for the LCD window controller.
package lcd_ctrl_win_pkg;

  localparam logic [3:0] CMD_WRITE   = 4'd0;
  localparam logic [3:0] CMD_UP      = 4'd1;
  localparam logic [3:0] CMD_DOWN    = 4'd2;
  localparam logic [3:0] CMD_LEFT    = 4'd3;
  localparam logic [3:0] CMD_RIGHT   = 4'd4;
  localparam logic [3:0] CMD_AVG     = 4'd5;
  localparam logic [3:0] CMD_MIRX    = 4'd6;
  localparam logic [3:0] CMD_MIRY    = 4'd7;
  localparam logic [3:0] CMD_MAX     = 4'd8;
  localparam logic [3:0] CMD_MIN     = 4'd9;
  localparam logic [3:0] CMD_ROT_CW  = 4'd10;
  localparam logic [3:0] CMD_ROT_CCW = 4'd11;

  typedef enum logic [1:0] {LOAD, CMD, EXEC, WRITE} state_t;

  function automatic int calc_aw(input int w, input int h);
    return $clog2(w * h);
  endfunction

endpackage

// File: rtl/lcd_win_alu.sv
// Combinational average / max / min over the four pixels of the 2x2 window.
module lcd_win_alu #(
  parameter int DW = 8
) (
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  input  logic [DW-1:0] i_c,
  input  logic [DW-1:0] i_d,
  output logic [DW-1:0] o_avg,
  output logic [DW-1:0] o_max,
  output logic [DW-1:0] o_min
);

  logic [DW+1:0] w_sum;
  logic [DW-1:0] w_mx_ab, w_mx_cd, w_mn_ab, w_mn_cd;

  // Two guard bits keep the four-way sum exact before the floor divide.
  assign w_sum   = {2'b00, i_a} + {2'b00, i_b} + {2'b00, i_c} + {2'b00, i_d};
  assign o_avg   = w_sum[DW+1:2];

  assign w_mx_ab = (i_a > i_b) ? i_a : i_b;
  assign w_mx_cd = (i_c > i_d) ? i_c : i_d;
  assign o_max   = (w_mx_ab > w_mx_cd) ? w_mx_ab : w_mx_cd;

  assign w_mn_ab = (i_a < i_b) ? i_a : i_b;
  assign w_mn_cd = (i_c < i_d) ? i_c : i_d;
  assign o_min   = (w_mn_ab < w_mn_cd) ? w_mn_ab : w_mn_cd;

endmodule

// File: rtl/lcd_ctrl_win.sv
// LCD image controller: ROM load, 2x2 window ops, IRB write-out.
// Define LCD_CTRL_WIN_ROTATE_EN to enable rotate codes 10/11 (otherwise they are NOPs).
module lcd_ctrl_win
  import lcd_ctrl_win_pkg::*;
#(
  parameter  int DW    = 8,
  parameter  int IMG_W = 8,
  parameter  int IMG_H = 8,
  localparam int AW    = calc_aw(IMG_W, IMG_H)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] IROM_Q,
  input  logic [3:0]    cmd,
  input  logic          cmd_valid,
  output logic          IROM_EN,
  output logic [AW-1:0] IROM_A,
  output logic          IRB_RW,
  output logic [DW-1:0] IRB_D,
  output logic [AW-1:0] IRB_A,
  output logic          busy,
  output logic          done
);

  localparam int N  = IMG_W * IMG_H;
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  state_t        r_state;
  logic [3:0]    r_cmd;
  logic [XW-1:0] r_opx;
  logic [YW-1:0] r_opy;
  logic [AW-1:0] r_prev;
  logic          r_cap;
  logic [DW-1:0] r_buf [N];

  logic [AW-1:0] w_ia, w_ib, w_ic, w_id, w_wr_nxt;
  logic [DW-1:0] w_a, w_b, w_c, w_d, w_avg, w_max, w_min;
  logic [DW-1:0] w_na, w_nb, w_nc, w_nd;

  // Power-of-2 geometry makes y*IMG_W+x a plain concatenation.
  assign w_ia     = {r_opy, r_opx};
  assign w_ib     = {r_opy, r_opx + 1'b1};
  assign w_ic     = {r_opy + 1'b1, r_opx};
  assign w_id     = {r_opy + 1'b1, r_opx + 1'b1};
  assign w_wr_nxt = IRB_A + 1'b1;

  assign w_a = r_buf[w_ia];
  assign w_b = r_buf[w_ib];
  assign w_c = r_buf[w_ic];
  assign w_d = r_buf[w_id];

  lcd_win_alu #(.DW(DW)) u_alu (
    .i_a(w_a), .i_b(w_b), .i_c(w_c), .i_d(w_d),
    .o_avg(w_avg), .o_max(w_max), .o_min(w_min)
  );

  always_comb begin
    w_na = w_a;
    w_nb = w_b;
    w_nc = w_c;
    w_nd = w_d;
    case (r_cmd)
      CMD_AVG:     begin w_na = w_avg; w_nb = w_avg; w_nc = w_avg; w_nd = w_avg; end
      CMD_MIRX:    begin w_na = w_c;   w_nb = w_d;   w_nc = w_a;   w_nd = w_b;   end
      CMD_MIRY:    begin w_na = w_b;   w_nb = w_a;   w_nc = w_d;   w_nd = w_c;   end
      CMD_MAX:     begin w_na = w_max; w_nb = w_max; w_nc = w_max; w_nd = w_max; end
      CMD_MIN:     begin w_na = w_min; w_nb = w_min; w_nc = w_min; w_nd = w_min; end
`ifdef LCD_CTRL_WIN_ROTATE_EN
      CMD_ROT_CW:  begin w_na = w_c;   w_nb = w_a;   w_nc = w_d;   w_nd = w_b;   end
      CMD_ROT_CCW: begin w_na = w_b;   w_nb = w_d;   w_nc = w_a;   w_nd = w_c;   end
`endif
      default: ;
    endcase
  end

  // Shifts and NOPs write back the unchanged window, so EXEC always writes all four.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) r_buf[i] <= '0;
    end else if (r_state == LOAD && r_cap) begin
      r_buf[r_prev] <= IROM_Q;
    end else if (r_state == EXEC) begin
      r_buf[w_ia] <= w_na;
      r_buf[w_ib] <= w_nb;
      r_buf[w_ic] <= w_nc;
      r_buf[w_id] <= w_nd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= LOAD;
      r_cmd   <= CMD_WRITE;
      r_opx   <= XW'(IMG_W / 2 - 1);
      r_opy   <= YW'(IMG_H / 2 - 1);
      r_prev  <= '0;
      r_cap   <= 1'b0;
      IROM_EN <= 1'b0;
      IROM_A  <= '0;
      IRB_RW  <= 1'b1;
      IRB_D   <= '0;
      IRB_A   <= '0;
      busy    <= 1'b1;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        LOAD: begin
          // ROM data lags the address by one cycle; r_prev tracks which slot it fills.
          r_cap  <= 1'b1;
          r_prev <= IROM_A;
          if (IROM_A != AW'(N - 1)) IROM_A <= IROM_A + 1'b1;
          if (r_cap && r_prev == AW'(N - 1)) begin
            IROM_EN <= 1'b1;
            busy    <= 1'b0;
            r_state <= CMD;
          end
        end
        CMD: begin
          if (busy) begin
            busy <= 1'b0;
          end else if (cmd_valid) begin
            r_cmd <= cmd;
            busy  <= 1'b1;
            if (cmd == CMD_WRITE) begin
              r_state <= WRITE;
              IRB_RW  <= 1'b0;
              IRB_A   <= '0;
              IRB_D   <= r_buf[0];
            end else begin
              r_state <= EXEC;
            end
          end
        end
        EXEC: begin
          case (r_cmd)
            CMD_UP:    if (r_opy != '0) r_opy <= r_opy - 1'b1;
            CMD_DOWN:  if (r_opy != YW'(IMG_H - 2)) r_opy <= r_opy + 1'b1;
            CMD_LEFT:  if (r_opx != '0) r_opx <= r_opx - 1'b1;
            CMD_RIGHT: if (r_opx != XW'(IMG_W - 2)) r_opx <= r_opx + 1'b1;
            default: ;
          endcase
          r_state <= CMD;
        end
        WRITE: begin
          if (IRB_A == AW'(N - 1)) begin
            IRB_RW  <= 1'b1;
            IRB_A   <= '0;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= CMD;
          end else begin
            IRB_A <= w_wr_nxt;
            IRB_D <= r_buf[w_wr_nxt];
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

endmodule
